// File: rtl/clz_pkg.sv
// Shared types and helpers for the pipelined leading-zero counter.
// Optional feature macro used by clz_pipe: CLZ_PIPE_CLO_EN (count leading ones).
package clz_pkg;

    localparam int MAX_N     = 64;
    localparam int MAX_TAG_W = 16;

    // Width needed to hold a count in 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int MAX_CW = cnt_w(MAX_N);

    // One pipeline stage's result view: sized for the largest supported operand and tag.
    typedef struct packed {
        logic                 valid;
        logic [MAX_CW-1:0]    count;
        logic                 allzero;
        logic [MAX_TAG_W-1:0] tag;
    } stage_t;

endpackage

// File: rtl/clz_node.sv
// One combine step of the leading-zero tree: merges the results of two
// adjacent halves of width HALF_W into the result for the joined field.
module clz_node
    import clz_pkg::*;
#(
    parameter int HALF_W = 1,
    parameter int CW     = 6
) (
    input  logic [CW-1:0] cnt_hi_i,
    input  logic [CW-1:0] cnt_lo_i,
    input  logic          az_hi_i,
    input  logic          az_lo_i,
    output logic [CW-1:0] cnt_o,
    output logic          az_o
);

    localparam logic [CW-1:0] HALF = CW'(HALF_W);

    // An all-zero upper half passes its full width plus the lower count; otherwise the upper count wins.
    always_comb begin
        cnt_o = az_hi_i ? (HALF + cnt_lo_i) : cnt_hi_i;
        az_o  = az_hi_i & az_lo_i;
    end

endmodule

// File: rtl/clz_pipe.sv
// Pipelined leading-zero counter (MIPS32 CLZ) with zero/nzero flags and a
// destination tag carried alongside. Valid/ready on both sides, one global
// advance signal: adv = out_ready | ~out_valid; every stage loads on adv,
// bubbles included, and in_ready = adv.
// Define CLZ_PIPE_CLO_EN to enable in_mode=1 (count leading ones, MIPS CLO).
module clz_pipe
    import clz_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_a,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic                in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [cnt_w(N)-1:0] out_count,
    output logic                out_zero,
    output logic                out_nzero,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int CW  = cnt_w(N);
    localparam int LOG = $clog2(N);

    // True when a register sits after tree level l: levels round(k*LOG/STAGES), k=1..STAGES.
    function automatic bit is_reg(input int l);
        bit hit;
        hit = 1'b0;
        for (int k = 1; k <= STAGES; k++) begin
            if (((2 * k * LOG + STAGES) / (2 * STAGES)) == l) hit = 1'b1;
        end
        return hit;
    endfunction

    logic         adv;
    logic [N-1:0] opnd;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

`ifdef CLZ_PIPE_CLO_EN
    // Counting ones is counting zeros of the inverted operand.
    assign opnd = in_mode ? ~in_a : in_a;
`else
    logic unused_mode;
    assign unused_mode = in_mode;
    assign opnd        = in_a;
`endif

    for (genvar l = 0; l <= LOG; l++) begin : g_lvl
        localparam int NN = N >> l;

        logic [CW-1:0]    cnt [NN];
        logic             az  [NN];
        logic             v;
        logic             oz;
        logic             nz;
        logic [TAG_W-1:0] tag;

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < NN; i++) begin : g_bit
                assign cnt[i] = {{(CW-1){1'b0}}, ~opnd[i]};
                assign az[i]  = ~opnd[i];
            end
            // Flags always describe the original operand, independent of mode.
            assign v   = in_valid;
            assign oz  = ~|in_a;
            assign nz  = |in_a;
            assign tag = in_tag;
        end else begin : g_comb
            logic [CW-1:0] c_cnt [NN];
            logic          c_az  [NN];

            for (genvar j = 0; j < NN; j++) begin : g_node
                clz_node #(
                    .HALF_W (1 << (l - 1)),
                    .CW     (CW)
                ) u_node (
                    .cnt_hi_i (g_lvl[l-1].cnt[2*j+1]),
                    .cnt_lo_i (g_lvl[l-1].cnt[2*j]),
                    .az_hi_i  (g_lvl[l-1].az[2*j+1]),
                    .az_lo_i  (g_lvl[l-1].az[2*j]),
                    .cnt_o    (c_cnt[j]),
                    .az_o     (c_az[j])
                );
            end

            if (is_reg(l)) begin : g_reg
                // Stage register: loads from the previous level on adv, holds otherwise; reset flushes.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        v   <= 1'b0;
                        oz  <= 1'b0;
                        nz  <= 1'b0;
                        tag <= '0;
                        for (int j = 0; j < NN; j++) begin
                            cnt[j] <= '0;
                            az[j]  <= 1'b0;
                        end
                    end else if (adv) begin
                        v   <= g_lvl[l-1].v;
                        oz  <= g_lvl[l-1].oz;
                        nz  <= g_lvl[l-1].nz;
                        tag <= g_lvl[l-1].tag;
                        for (int j = 0; j < NN; j++) begin
                            cnt[j] <= c_cnt[j];
                            az[j]  <= c_az[j];
                        end
                    end
                end
            end else begin : g_pass
                // Unregistered level: results flow straight to the next level.
                always_comb begin
                    v   = g_lvl[l-1].v;
                    oz  = g_lvl[l-1].oz;
                    nz  = g_lvl[l-1].nz;
                    tag = g_lvl[l-1].tag;
                    for (int j = 0; j < NN; j++) begin
                        cnt[j] = c_cnt[j];
                        az[j]  = c_az[j];
                    end
                end
            end
        end
    end

    stage_t out_st;

    // Collect the final (always registered) level into the output view.
    always_comb begin
        out_st         = '0;
        out_st.valid   = g_lvl[LOG].v;
        out_st.count   = MAX_CW'(g_lvl[LOG].cnt[0]);
        out_st.allzero = g_lvl[LOG].oz;
        out_st.tag     = MAX_TAG_W'(g_lvl[LOG].tag);
    end

    assign out_valid = out_st.valid;
    assign out_count = CW'(out_st.count);
    assign out_zero  = out_st.allzero;
    assign out_nzero = g_lvl[LOG].nz;
    assign out_tag   = TAG_W'(out_st.tag);

endmodule

// File: tb/tb_clz_pipe.sv
// Bench for clz_pipe (N=32, STAGES=2, TAG_W=5): directed vectors, expected
// results queued at acceptance, popped and compared by an output monitor.
module tb_clz_pipe;

  localparam int N      = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;
  localparam int CW     = 6;
  localparam int EW     = 30;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_a = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    out_count;
  logic             out_zero;
  logic             out_nzero;
  logic [TAG_W-1:0] out_tag;

  clz_pipe #(.N(N), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_tag    (in_tag),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_zero  (out_zero),
    .out_nzero (out_nzero),
    .out_tag   (out_tag)
  );

  int total = 0;
  int bad   = 0;
  logic lat_en = 1'b1;

  // entry: {lat_chk, acc_cyc[15:0], tag[4:0], zero, nzero, count[5:0]}
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: present one operand, wait (bounded) for acceptance, queue its expected result
  task automatic send(input logic [N-1:0] a, input logic [TAG_W-1:0] tag, input logic mode,
                      input logic [CW-1:0] ecnt, input logic ez);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_tag   = tag;
    in_mode  = mode;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back({lat_en & out_ready, 16'(cyc), tag, ez, ~ez, ecnt});
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // scoreboard monitor
  logic          held = 1'b0;
  logic [CW-1:0] h_count;
  logic          h_zero, h_nzero;
  logic [TAG_W-1:0] h_tag;
  logic [EW-1:0] e;

  always @(negedge clk) begin
    if (!rst) begin
      if (held) begin
        check("hold_valid", out_valid, 32'd1);
        check("hold_count", out_count, h_count);
        check("hold_zero", out_zero, h_zero);
        check("hold_nzero", out_nzero, h_nzero);
        check("hold_tag", out_tag, h_tag);
      end
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("count", out_count, e[5:0]);
          check("nzero", out_nzero, e[6]);
          check("zero", out_zero, e[7]);
          check("tag", out_tag, e[12:8]);
          if (e[29]) check("latency", cyc - int'(e[28:13]), STAGES);
        end
      end
      held    = out_valid && !out_ready;
      h_count = out_count;
      h_zero  = out_zero;
      h_nzero = out_nzero;
      h_tag   = out_tag;
    end else begin
      held = 1'b0;
    end
  end

  logic [N-1:0]  bp_a [8] = '{32'h4000_0000, 32'h2000_0000, 32'h00F0_0000, 32'h0000_0100,
                              32'h0000_000F, 32'h0000_0002, 32'h1000_0000, 32'h0000_0000};
  logic [CW-1:0] bp_c [8] = '{6'd1, 6'd2, 6'd8, 6'd23, 6'd28, 6'd30, 6'd3, 6'd32};

  initial begin
    #2;
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_count", out_count, 32'd0);
    check("rst_out_zero", out_zero, 32'd0);
    check("rst_out_nzero", out_nzero, 32'd0);
    check("rst_out_tag", out_tag, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 32'd1);

    // walking one
    out_ready = 1'b1;
    lat_en    = 1'b1;
    for (int i = 0; i < 32; i++) send(32'd1 << i, TAG_W'(i), 1'b0, CW'(31 - i), 1'b0);
    drain();

    // zero operand and back-to-back stream
    send(32'h0000_0000, 5'd7, 1'b0, 6'd32, 1'b1);
    send(32'h8000_0000, 5'd1, 1'b0, 6'd0, 1'b0);
    send(32'h0001_0000, 5'd2, 1'b0, 6'd15, 1'b0);
    send(32'h0000_0001, 5'd3, 1'b0, 6'd31, 1'b0);
    send(32'h7FFF_FFFF, 5'd4, 1'b0, 6'd1, 1'b0);
    send(32'h0000_FFFF, 5'd5, 1'b0, 6'd16, 1'b0);
    send(32'h0000_8000, 5'd6, 1'b0, 6'd16, 1'b0);
    drain();

    // backpressure while streaming
    lat_en = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(bp_a[i], TAG_W'(16 + i), 1'b0, bp_c[i], bp_a[i] == '0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset mid-operation: two operands accepted, then flushed
    out_ready = 1'b0;
    send(32'h0000_0400, 5'd20, 1'b0, 6'd21, 1'b0);
    send(32'h0000_0800, 5'd21, 1'b0, 6'd20, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 32'd0);
    check("midrst_out_count", out_count, 32'd0);
    check("midrst_out_tag", out_tag, 32'd0);
    check("midrst_out_nzero", out_nzero, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_idle", out_valid, 32'd0);
    end
    check("post_rst_in_ready", in_ready, 32'd1);

    // mode input
    lat_en = 1'b1;
    @(posedge clk);
    #1;
`ifdef CLZ_PIPE_CLO_EN
    send(32'hFFF0_0000, 5'd9, 1'b1, 6'd12, 1'b0);
    send(32'hFFFF_FFFF, 5'd10, 1'b1, 6'd32, 1'b0);
    send(32'h0000_0000, 5'd11, 1'b1, 6'd0, 1'b1);
`else
    send(32'hFFF0_0000, 5'd9, 1'b1, 6'd0, 1'b0);
    send(32'hFFFF_FFFF, 5'd10, 1'b1, 6'd0, 1'b0);
    send(32'h0000_0000, 5'd11, 1'b1, 6'd32, 1'b1);
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
